interrupt_controller: RTL

//  Parametrised N-source interrupt controller in front of the pipelined MIPS CPU INT/NMI inputs.
//  - Latches edge/level requests, applies per-source mask and the CPU's INT_FLAG global enable.
//  - Selects the highest-priority source (lowest index) and runs a request/ack/EOI handshake.
//  - Presents a stable INT/INT_ID pair to the CPU. NMI is unmaskable and always beats maskable sources.

---
 rtl/interrupt_controller_if.sv | 28 ++
 rtl/interrupt_controller.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/interrupt_controller_if.sv
// Request/ack/EOI and mask bus between the interrupt controller (slave) and the CPU side (master).
interface interrupt_controller_if #(
    parameter int unsigned N_SRC = 8,
    parameter int unsigned ID_W  = 3
);
    logic [N_SRC-1:0] IRQ_IN;
    logic             NMI;
    logic             INT_FLAG;
    logic             MASK_WE;
    logic [N_SRC-1:0] MASK_WDATA;
    logic             INT_ACK;
    logic             EOI;
    logic             INT;
    logic [ID_W-1:0]  INT_ID;
    logic             INT_IS_NMI;
    logic [N_SRC-1:0] MASK;
    logic [N_SRC-1:0] PENDING;

    modport master (
        output IRQ_IN, NMI, INT_FLAG, MASK_WE, MASK_WDATA, INT_ACK, EOI,
        input  INT, INT_ID, INT_IS_NMI, MASK, PENDING
    );

    modport slave (
        input  IRQ_IN, NMI, INT_FLAG, MASK_WE, MASK_WDATA, INT_ACK, EOI,
        output INT, INT_ID, INT_IS_NMI, MASK, PENDING
    );
endinterface

// File: rtl/interrupt_controller.sv
// N-source prioritised interrupt controller with unmaskable NMI and request/ack/EOI handshake.
// Optional NESTED_NMI_EN: NMI may preempt a maskable handler in SERVICE via a 1-deep save slot.
module interrupt_controller #(
    parameter int unsigned      N_SRC     = 8,
    parameter int unsigned      ID_W      = 3,
    parameter logic [N_SRC-1:0] EDGE_MASK = '1
) (
    input logic                   CLK,
    input logic                   RST,
    interrupt_controller_if.slave bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] irq_prev_q, irq_prev_d;
    logic             nmi_prev_q, nmi_prev_d;
    logic             nmi_pend_q, nmi_pend_d;
    logic [ID_W-1:0]  int_id_q, int_id_d;
    logic             int_is_nmi_q, int_is_nmi_d;
`ifdef NESTED_NMI_EN
    logic [ID_W-1:0]  saved_id_q, saved_id_d;
    logic             saved_valid_q, saved_valid_d;
`endif

    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] ack_clr;
    logic [ID_W-1:0]  winner;
    logic             found;
    logic             ack_req;
    logic             eoi_svc;

    always_comb begin
        eligible = pending_q & mask_q & {N_SRC{bus.INT_FLAG}};
        winner   = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (eligible[i] && !found) begin
                winner = ID_W'(i);
                found  = 1'b1;
            end
        end

        ack_req = (state_q == S_REQ) && bus.INT_ACK;
        eoi_svc = (state_q == S_SERVICE) && bus.EOI && !bus.INT_ACK;
        ack_clr = '0;
        if (ack_req && !int_is_nmi_q) ack_clr[int_id_q] = 1'b1;

        // A fresh edge in the same cycle as the servicing ACK keeps the source pending.
        pending_d  = (EDGE_MASK & ((bus.IRQ_IN & ~irq_prev_q) | (pending_q & ~ack_clr)))
                   | (~EDGE_MASK & bus.IRQ_IN);
        irq_prev_d = bus.IRQ_IN;
        nmi_prev_d = bus.NMI;
        nmi_pend_d = (bus.NMI & ~nmi_prev_q) | (nmi_pend_q & ~(ack_req & int_is_nmi_q));
        mask_d     = bus.MASK_WE ? bus.MASK_WDATA : mask_q;

        state_d      = state_q;
        int_id_d     = int_id_q;
        int_is_nmi_d = int_is_nmi_q;
`ifdef NESTED_NMI_EN
        saved_id_d    = saved_id_q;
        saved_valid_d = saved_valid_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (nmi_pend_q) begin
                    state_d      = S_REQ;
                    int_id_d     = '0;
                    int_is_nmi_d = 1'b1;
                end else if (found) begin
                    state_d      = S_REQ;
                    int_id_d     = winner;
                    int_is_nmi_d = 1'b0;
                end
            end
            S_REQ: begin
                if (bus.INT_ACK) begin
                    state_d = S_SERVICE;
                end else if (!int_is_nmi_q) begin
                    if (nmi_pend_q) begin
                        int_id_d     = '0;
                        int_is_nmi_d = 1'b1;
                    end else if (!eligible[int_id_q]) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_SERVICE: begin
                if (eoi_svc) begin
                    state_d = S_IDLE;
`ifdef NESTED_NMI_EN
                    if (int_is_nmi_q && saved_valid_q) begin
                        state_d       = S_SERVICE;
                        int_id_d      = saved_id_q;
                        int_is_nmi_d  = 1'b0;
                        saved_valid_d = 1'b0;
                    end
                end else if (!int_is_nmi_q && nmi_pend_q) begin
                    state_d       = S_REQ;
                    saved_id_d    = int_id_q;
                    saved_valid_d = 1'b1;
                    int_id_d      = '0;
                    int_is_nmi_d  = 1'b1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_IDLE;
            pending_q     <= '0;
            mask_q        <= '0;
            irq_prev_q    <= '0;
            nmi_prev_q    <= 1'b0;
            nmi_pend_q    <= 1'b0;
            int_id_q      <= '0;
            int_is_nmi_q  <= 1'b0;
`ifdef NESTED_NMI_EN
            saved_id_q    <= '0;
            saved_valid_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            mask_q        <= mask_d;
            irq_prev_q    <= irq_prev_d;
            nmi_prev_q    <= nmi_prev_d;
            nmi_pend_q    <= nmi_pend_d;
            int_id_q      <= int_id_d;
            int_is_nmi_q  <= int_is_nmi_d;
`ifdef NESTED_NMI_EN
            saved_id_q    <= saved_id_d;
            saved_valid_q <= saved_valid_d;
`endif
        end
    end

    assign bus.INT        = (state_q == S_REQ);
    assign bus.INT_ID     = int_id_q;
    assign bus.INT_IS_NMI = int_is_nmi_q;
    assign bus.MASK       = mask_q;
    assign bus.PENDING    = pending_q;
endmodule
